rx: RTL and testbench

UART receiver; downstream partner of the tx transmitter. Frame format is fixed at 1 start bit, 8 data bits LSB first, 1 odd-parity bit and 1 stop bit.
The block deserialises the line, checks parity and framing, then presents the byte to the consumer with a four-phase Receive/ReceiveAck handshake. The consumer is an LED/seven-segment display or a loopback FIFO.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/baud_timer.sv | 24 ++
 rtl/rx.sv | 128 ++++++++++++
 tb/tb_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, default baud divisor, data width
// and the odd-parity helper used by both tx and rx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BITS  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4,
        ACK   = 3'd5
    } frame_state_t;

    localparam int unsigned BIT_CLKS_19200 = 5208;
    localparam int unsigned DATA_BITS      = 8;

    // Parity bit that makes data plus parity hold an odd number of 1s.
    function automatic logic odd_par(input logic [DATA_BITS-1:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/baud_timer.sv
// Free-running bit-period timer: counts up every cycle, wraps to zero at
// TERMINAL or whenever the owning FSM asks for a clear.
module baud_timer #(
    parameter int unsigned WIDTH    = 13,
    parameter int unsigned TERMINAL = 5207
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    assign done = (count == WIDTH'(TERMINAL));

    // Count up, restarting on reset, clear request or terminal count.
    always_ff @(posedge clk) begin
        if (Reset || clear || done)
            count <= '0;
        else
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/rx.sv
// UART receiver: 1 start, 8 data (LSB first), odd parity, 1 stop.
// Received bytes are offered with a four-phase Receive/ReceiveAck handshake.
module rx
    import uart_pkg::*;
#(
    parameter int unsigned BIT_CLKS  = BIT_CLKS_19200,
    parameter int unsigned HALF_CLKS = BIT_CLKS / 2
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Sin,
    input  logic       ReceiveAck,
    output logic       Receive,
    output logic [7:0] Dout,
    output logic       parityErr,
    output logic       frameErr
);

    localparam int unsigned TW = 13;

    logic                 sMeta;
    logic                 sSin;
    frame_state_t         state;
    frame_state_t         stateNext;
    logic                 timerClear;
    logic [TW-1:0]        timer;
    logic                 bitDone;
    logic                 halfHit;
    logic [2:0]           bitCount;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 parBit;

    baud_timer #(
        .WIDTH    (TW),
        .TERMINAL (BIT_CLKS - 1)
    ) uTimer (
        .clk   (clk),
        .Reset (Reset),
        .clear (timerClear),
        .count (timer),
        .done  (bitDone)
    );

    assign halfHit = (timer == TW'(HALF_CLKS - 1));
    assign Receive = (state == ACK);

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk) begin
        if (Reset) begin
            sMeta <= 1'b1;
            sSin  <= 1'b1;
        end else begin
            sMeta <= Sin;
            sSin  <= sMeta;
        end
    end

    // Next-state and timer-clear decode for the frame FSM.
    always_comb begin
        stateNext  = state;
        timerClear = 1'b0;
        case (state)
            IDLE: begin
                timerClear = 1'b1;
                if (!sSin) stateNext = START;
            end
            START: begin
                if (halfHit) begin
                    if (!sSin) begin
                        stateNext  = BITS;
                        timerClear = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            BITS:  if (bitDone && bitCount == 3'(DATA_BITS - 1)) stateNext = PAR;
            PAR:   if (bitDone) stateNext = STOP;
            STOP:  if (bitDone) stateNext = ACK;
            ACK: begin
                timerClear = 1'b1;
                if (ReceiveAck) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // Bit-centre sampling, parity capture and result registers.
    always_ff @(posedge clk) begin
        if (Reset) begin
            bitCount  <= '0;
            shiftReg  <= '0;
            parBit    <= 1'b0;
            Dout      <= '0;
            parityErr <= 1'b0;
            frameErr  <= 1'b0;
        end else begin
            case (state)
                START: if (halfHit && !sSin) bitCount <= '0;
                BITS: begin
                    if (bitDone) begin
                        shiftReg[bitCount] <= sSin;
                        if (bitCount != 3'(DATA_BITS - 1))
                            bitCount <= bitCount + 3'd1;
                    end
                end
                PAR: if (bitDone) parBit <= sSin;
                STOP: begin
                    if (bitDone) begin
                        Dout      <= shiftReg;
                        parityErr <= odd_par(shiftReg) ^ parBit;
                        frameErr  <= ~sSin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rx.sv
// Self-checking bench for rx, with the bit period shortened for simulation.
module tb_rx;

    localparam int unsigned B = 32;
    localparam int unsigned H = 16;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Sin = 1'b1;
    logic       ReceiveAck = 1'b0;
    logic       Receive;
    logic [7:0] Dout;
    logic       parityErr;
    logic       frameErr;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int unsigned startCyc = 0;
    int          ackDelay = 10;
    bit          autoAck = 1'b1;
    int          stableBad = 0;

    logic [7:0] qD[$];
    bit         qP[$];
    bit         qF[$];
    int         qH[$];
    int         qLat[$];

    rx #(.BIT_CLKS(B), .HALF_CLKS(H)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .Sin        (Sin),
        .ReceiveAck (ReceiveAck),
        .Receive    (Receive),
        .Dout       (Dout),
        .parityErr  (parityErr),
        .frameErr   (frameErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Consumer: records each byte offered, checks it stays stable, acks it.
    initial begin
        logic [7:0] d;
        bit p, f;
        int hc;
        forever begin
            @(negedge clk);
            if (Receive === 1'b1) begin
                d = Dout; p = parityErr; f = frameErr;
                qD.push_back(d); qP.push_back(p); qF.push_back(f);
                qLat.push_back(int'(cyc - startCyc));
                hc = 0;
                while (Receive === 1'b1 && hc < 1000) begin
                    hc++;
                    if (Dout !== d || parityErr !== p || frameErr !== f) stableBad++;
                    if (autoAck && hc == ackDelay + 1) ReceiveAck = 1'b1;
                    @(negedge clk);
                end
                ReceiveAck = 1'b0;
                qH.push_back(hc);
            end
        end
    end

    // Reference rules for a frame as it appeared on the line.
    function automatic bit exp_perr(input logic [7:0] d, input bit p);
        return ((($countones(d) + int'(p)) % 2) == 0);
    endfunction

    function automatic bit good_par(input logic [7:0] d);
        return (($countones(d) % 2) == 0);
    endfunction

    task automatic send_frame(input logic [7:0] d, input bit p, input bit s);
        @(negedge clk);
        startCyc = cyc;
        Sin = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            Sin = d[i];
            repeat (B) @(negedge clk);
        end
        Sin = p;
        repeat (B) @(negedge clk);
        Sin = s;
        repeat (B) @(negedge clk);
        Sin = 1'b1;
    endtask

    task automatic get_frame(output bit got, output logic [7:0] d, output bit p,
                             output bit f, output int h, output int lat);
        for (int i = 0; i < 3000 && qH.size() == 0; i++) @(negedge clk);
        got = (qH.size() > 0 && qD.size() > 0);
        d = 8'hxx; p = 1'bx; f = 1'bx; h = -1; lat = -1;
        if (got) begin
            d = qD.pop_front(); p = qP.pop_front(); f = qF.pop_front();
            h = qH.pop_front(); lat = qLat.pop_front();
        end
    endtask

    task automatic clear_queues();
        qD.delete(); qP.delete(); qF.delete(); qH.delete(); qLat.delete();
    endtask

    task automatic test_reset();
        int bad = 0;
        Reset = 1'b1; Sin = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (Receive !== 1'b0) begin fails++; $display("FAIL reset_receive: got %b want 0", Receive); end
        tests++; if (Dout !== 8'h00) begin fails++; $display("FAIL reset_dout: got %h want 00", Dout); end
        tests++; if ({parityErr, frameErr} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b want 00", {parityErr, frameErr}); end
        Reset = 1'b0;
        repeat (2000) begin
            @(negedge clk);
            if (Receive !== 1'b0 || Dout !== 8'h00 || parityErr !== 1'b0 || frameErr !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL idle_quiet: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_basic();
        bit got, p, f; logic [7:0] d; int h, lat;
        ackDelay = 10;
        send_frame(8'h41, 1'b1, 1'b1);
        get_frame(got, d, p, f, h, lat);
        tests++; if (!got) begin fails++; $display("FAIL basic_seen: got none want one byte"); end
        tests++; if (d !== 8'h41) begin fails++; $display("FAIL basic_dout: got %h want 41", d); end
        tests++; if (p !== 1'b0 || f !== 1'b0) begin fails++; $display("FAIL basic_flags: got %b%b want 00", p, f); end
        tests++; if (h !== 11) begin fails++; $display("FAIL basic_high: got %0d want 11", h); end
        tests++; if (lat > int'(H + 10 * B + 4)) begin fails++; $display("FAIL basic_latency: got %0d want <= %0d", lat, H + 10 * B + 4); end
        send_frame(8'hFF, 1'b0, 1'b1);
        get_frame(got, d, p, f, h, lat);
        tests++; if (d !== 8'hFF) begin fails++; $display("FAIL badpar_dout: got %h want FF", d); end
        tests++; if (p !== 1'b1 || f !== 1'b0) begin fails++; $display("FAIL badpar_flags: got %b%b want 10", p, f); end
    endtask

    task automatic test_frame_error();
        bit got, p, f; logic [7:0] d; int h, lat;
        send_frame(8'h5A, good_par(8'h5A), 1'b0);
        get_frame(got, d, p, f, h, lat);
        tests++; if (d !== 8'h5A) begin fails++; $display("FAIL ferr_dout: got %h want 5A", d); end
        tests++; if (f !== 1'b1 || p !== 1'b0) begin fails++; $display("FAIL ferr_flags: got %b%b want 01", p, f); end
        repeat (2 * B) @(negedge clk);
        tests++; if (qH.size() !== 0) begin fails++; $display("FAIL ferr_spurious: got %0d extra bytes want 0", qH.size()); end
        send_frame(8'h3C, good_par(8'h3C), 1'b1);
        get_frame(got, d, p, f, h, lat);
        tests++; if (d !== 8'h3C || p !== 1'b0 || f !== 1'b0) begin fails++; $display("FAIL resync: got %h/%b%b want 3C/00", d, p, f); end
    endtask

    task automatic test_glitch();
        bit got, p, f; logic [7:0] d; int h, lat;
        @(negedge clk); Sin = 1'b0;
        repeat (H / 2) @(negedge clk);
        Sin = 1'b1;
        repeat (3 * B) @(negedge clk);
        tests++; if (qH.size() !== 0 || Receive !== 1'b0) begin fails++; $display("FAIL glitch: got %0d bytes want 0", qH.size()); end
        send_frame(8'h00, 1'b1, 1'b1);
        get_frame(got, d, p, f, h, lat);
        tests++; if (d !== 8'h00 || p !== 1'b0 || f !== 1'b0) begin fails++; $display("FAIL after_glitch: got %h/%b%b want 00/00", d, p, f); end
    endtask

    task automatic test_reset_bits();
        bit got, p, f; logic [7:0] d; int h, lat;
        logic [7:0] v = 8'hA5;
        @(negedge clk); Sin = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            Sin = v[i];
            repeat (B / 2) @(negedge clk);
            if (i == 3) begin
                Reset = 1'b1; Sin = 1'b1;
                @(negedge clk);
                Reset = 1'b0;
            end
            repeat (B / 2) @(negedge clk);
        end
        Sin = 1'b1;
        repeat (12 * B) @(negedge clk);
        tests++; if (qH.size() !== 0) begin fails++; $display("FAIL reset_bits_drop: got %0d bytes want 0", qH.size()); end
        send_frame(8'h81, good_par(8'h81), 1'b1);
        get_frame(got, d, p, f, h, lat);
        tests++; if (d !== 8'h81 || p !== 1'b0 || f !== 1'b0) begin fails++; $display("FAIL reset_bits_next: got %h/%b%b want 81/00", d, p, f); end
    endtask

    task automatic test_reset_ack();
        int n = 0;
        autoAck = 1'b0;
        send_frame(8'h77, good_par(8'h77), 1'b1);
        while (Receive !== 1'b1 && n < 1000) begin n++; @(negedge clk); end
        tests++; if (Receive !== 1'b1) begin fails++; $display("FAIL reset_ack_wait: got %b want 1", Receive); end
        repeat (5) @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        tests++; if (Receive !== 1'b0) begin fails++; $display("FAIL reset_ack_receive: got %b want 0", Receive); end
        tests++; if (Dout !== 8'h00) begin fails++; $display("FAIL reset_ack_dout: got %h want 00", Dout); end
        repeat (3) @(negedge clk);
        clear_queues();
        autoAck = 1'b1;
    endtask

    task automatic test_random();
        bit got, p, f, pb; logic [7:0] d, v; int h, lat;
        for (int k = 0; k < 12; k++) begin
            v = 8'($urandom);
            pb = ($urandom_range(0, 3) == 0) ? ~good_par(v) : good_par(v);
            ackDelay = int'($urandom_range(0, 12));
            send_frame(v, pb, 1'b1);
            get_frame(got, d, p, f, h, lat);
            tests++; if (d !== v || p !== exp_perr(v, pb) || f !== 1'b0)
                begin fails++; $display("FAIL random_%0d: got %h/%b%b want %h/%b0", k, d, p, f, v, exp_perr(v, pb)); end
            tests++; if (h !== ackDelay + 1) begin fails++; $display("FAIL random_high_%0d: got %0d want %0d", k, h, ackDelay + 1); end
        end
        ackDelay = 10;
    endtask

    task automatic test_back_to_back();
        bit got, p, f; logic [7:0] d; int h, lat;
        logic [7:0] v[3] = '{8'h12, 8'hED, 8'h80};
        for (int k = 0; k < 3; k++) send_frame(v[k], good_par(v[k]), 1'b1);
        for (int k = 0; k < 3; k++) begin
            get_frame(got, d, p, f, h, lat);
            tests++; if (d !== v[k] || p !== 1'b0 || f !== 1'b0)
                begin fails++; $display("FAIL b2b_%0d: got %h/%b%b want %h/00", k, d, p, f, v[k]); end
        end
        tests++; if (stableBad !== 0) begin fails++; $display("FAIL stable: got %0d changes during ACK want 0", stableBad); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_error();
        test_glitch();
        test_reset_bits();
        test_reset_ack();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
